// File: rtl/fe_redirect_sched_if.sv
// fe_redirect_sched_if: request/redirect bundle for the front-end redirect scheduler.
//   master : redirect sources and consumers (drive requests, observe redirect)
//   slave  : fe_redirect_sched
//   Requests : RobRedir/RobPc, PreRedir/PrePc, BpTrap
//   Redirect : RedirValid, RedirPc, RedirSrc, FlushFe, StallFe, Busy
//   Optional : PerfRobCnt, PerfPreCnt, PerfTrapCnt when FE_REDIR_PERF_EN is defined
interface fe_redirect_sched_if #(
    parameter int unsigned PC_W = 32
`ifdef FE_REDIR_PERF_EN
    , parameter int unsigned CNT_W = 16
`endif
);
    logic            RobRedir;
    logic [PC_W-1:0] RobPc;
    logic            PreRedir;
    logic [PC_W-1:0] PrePc;
    logic            BpTrap;
    logic            RedirValid;
    logic [PC_W-1:0] RedirPc;
    logic [1:0]      RedirSrc;
    logic            FlushFe;
    logic            StallFe;
    logic            Busy;
`ifdef FE_REDIR_PERF_EN
    logic [CNT_W-1:0] PerfRobCnt;
    logic [CNT_W-1:0] PerfPreCnt;
    logic [CNT_W-1:0] PerfTrapCnt;
`endif

    modport master (
        output RobRedir, RobPc, PreRedir, PrePc, BpTrap,
        input  RedirValid, RedirPc, RedirSrc, FlushFe, StallFe, Busy
`ifdef FE_REDIR_PERF_EN
        , input PerfRobCnt, PerfPreCnt, PerfTrapCnt
`endif
    );

    modport slave (
        input  RobRedir, RobPc, PreRedir, PrePc, BpTrap,
        output RedirValid, RedirPc, RedirSrc, FlushFe, StallFe, Busy
`ifdef FE_REDIR_PERF_EN
        , output PerfRobCnt, PerfPreCnt, PerfTrapCnt
`endif
    );
endinterface

// File: rtl/fe_redirect_sched.sv
// fe_redirect_sched: arbitrates ROB redirect > predecode redirect > BPU/ICache trap,
// issues a one-cycle flush followed by RECOVER_CYC stall cycles, and holds the
// front end stalled on a trap until the ROB redirects.
//   Clk  : clock, all state on posedge
//   Rest : synchronous active-high reset
//   Bus  : fe_redirect_sched_if.slave (requests in, registered redirect outputs)
// Optional feature macro: FE_REDIR_PERF_EN adds saturating per-source event
// counters (PerfRobCnt/PerfPreCnt/PerfTrapCnt) and the CNT_W parameter.
module fe_redirect_sched #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned RECOVER_CYC = 2
`ifdef FE_REDIR_PERF_EN
    , parameter int unsigned CNT_W     = 16
`endif
) (
    input  logic               Clk,
    input  logic               Rest,
    fe_redirect_sched_if.slave Bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FLUSH    = 2'd1;
    localparam logic [1:0] RECOVER  = 2'd2;
    localparam logic [1:0] TRAPWAIT = 2'd3;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_ROB  = 2'b01;
    localparam logic [1:0] SRC_PRE  = 2'b10;

    localparam int unsigned CNT_BITS = 4;
    // Remaining RECOVER cycles after the first one; unused when RECOVER_CYC is 0.
    localparam logic [CNT_BITS-1:0] CNT_INIT =
        (RECOVER_CYC == 0) ? '0 : CNT_BITS'(RECOVER_CYC - 1);

    logic [1:0]          state, stateNext;
    logic [CNT_BITS-1:0] cnt, cntNext;
    logic [PC_W-1:0]     redirPcQ, redirPcNext;
    logic [1:0]          redirSrcQ, redirSrcNext;
    logic                flushQ, stallQ, busyQ;

    // Next-state, recovery counter and latched redirect target.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        redirPcNext  = redirPcQ;
        redirSrcNext = redirSrcQ;
        case (state)
            IDLE: begin
                if (Bus.RobRedir) begin
                    stateNext    = FLUSH;
                    redirPcNext  = Bus.RobPc;
                    redirSrcNext = SRC_ROB;
                end else if (Bus.PreRedir) begin
                    stateNext    = FLUSH;
                    redirPcNext  = Bus.PrePc;
                    redirSrcNext = SRC_PRE;
                end else if (Bus.BpTrap) begin
                    stateNext    = TRAPWAIT;
                end
            end
            FLUSH: begin
                if (Bus.RobRedir) begin
                    stateNext    = FLUSH;
                    redirPcNext  = Bus.RobPc;
                    redirSrcNext = SRC_ROB;
                end else if (RECOVER_CYC == 0) begin
                    stateNext    = IDLE;
                    redirPcNext  = '0;
                    redirSrcNext = SRC_NONE;
                end else begin
                    stateNext    = RECOVER;
                    cntNext      = CNT_INIT;
                end
            end
            RECOVER: begin
                if (Bus.RobRedir) begin
                    stateNext    = FLUSH;
                    redirPcNext  = Bus.RobPc;
                    redirSrcNext = SRC_ROB;
                end else if (cnt == '0) begin
                    stateNext    = IDLE;
                    redirPcNext  = '0;
                    redirSrcNext = SRC_NONE;
                end else begin
                    cntNext      = cnt - CNT_BITS'(1);
                end
            end
            TRAPWAIT: begin
                // Only the ROB can resolve a trap; re-asserted traps and predecode are stale.
                if (Bus.RobRedir) begin
                    stateNext    = FLUSH;
                    redirPcNext  = Bus.RobPc;
                    redirSrcNext = SRC_ROB;
                end
            end
            default: begin
                stateNext    = IDLE;
                redirPcNext  = '0;
                redirSrcNext = SRC_NONE;
            end
        endcase
    end

    // State and registered outputs; outputs are decoded from the next state.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            state     <= IDLE;
            cnt       <= '0;
            redirPcQ  <= '0;
            redirSrcQ <= SRC_NONE;
            flushQ    <= 1'b0;
            stallQ    <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            redirPcQ  <= redirPcNext;
            redirSrcQ <= redirSrcNext;
            flushQ    <= (stateNext == FLUSH);
            stallQ    <= (stateNext != IDLE);
            busyQ     <= (stateNext != IDLE);
        end
    end

    assign Bus.RedirValid = flushQ;
    assign Bus.FlushFe    = flushQ;
    assign Bus.StallFe    = stallQ;
    assign Bus.Busy       = busyQ;
    assign Bus.RedirPc    = redirPcQ;
    assign Bus.RedirSrc   = redirSrcQ;

`ifdef FE_REDIR_PERF_EN
    logic             robAcc, preAcc, trapAcc;
    logic [CNT_W-1:0] perfRob, perfPre, perfTrap;

    // ROB is accepted in every state; predecode and trap only from IDLE.
    assign robAcc  = Bus.RobRedir;
    assign preAcc  = (state == IDLE) && !Bus.RobRedir && Bus.PreRedir;
    assign trapAcc = (state == IDLE) && !Bus.RobRedir && !Bus.PreRedir && Bus.BpTrap;

    // Saturating event counters.
    always_ff @(posedge Clk) begin
        if (Rest) begin
            perfRob  <= '0;
            perfPre  <= '0;
            perfTrap <= '0;
        end else begin
            if (robAcc && (perfRob != '1))   perfRob  <= perfRob + CNT_W'(1);
            if (preAcc && (perfPre != '1))   perfPre  <= perfPre + CNT_W'(1);
            if (trapAcc && (perfTrap != '1)) perfTrap <= perfTrap + CNT_W'(1);
        end
    end

    assign Bus.PerfRobCnt  = perfRob;
    assign Bus.PerfPreCnt  = perfPre;
    assign Bus.PerfTrapCnt = perfTrap;
`endif
endmodule

// File: tb/tb_fe_redirect_sched.sv
// Testbench for fe_redirect_sched: directed scenarios plus a randomized run
// checked against an age-based reference model.
module tb_fe_redirect_sched;
    localparam int unsigned PC_W = 32;
    localparam int RC = 2;

    logic Clk;
    logic Rest;
    int   nErr;
    int   nChk;

    fe_redirect_sched_if #(.PC_W(PC_W)) b0 ();
    fe_redirect_sched_if #(.PC_W(PC_W)) b1 ();

    fe_redirect_sched #(.PC_W(PC_W), .RECOVER_CYC(RC)) dut0 (
        .Clk(Clk), .Rest(Rest), .Bus(b0)
    );
    fe_redirect_sched #(.PC_W(PC_W), .RECOVER_CYC(0)) dut1 (
        .Clk(Clk), .Rest(Rest), .Bus(b1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: cycles since last accepted flush, plus a trap-hold flag.
    int              mAge;
    bit              mTrap;
    logic [PC_W-1:0] mPc;
    logic [1:0]      mSrc;
    int              mRobCnt, mPreCnt, mTrapCnt;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_in();
        b0.RobRedir = 0; b0.RobPc = '0; b0.PreRedir = 0; b0.PrePc = '0; b0.BpTrap = 0;
        b1.RobRedir = 0; b1.RobPc = '0; b1.PreRedir = 0; b1.PrePc = '0; b1.BpTrap = 0;
    endtask

    task automatic test_reset();
        clear_in();
        Rest = 1;
        tick(); tick();
        Rest = 0;
        nChk++; if (b0.RedirValid !== 1'b0) begin nErr++; $display("FAIL reset_valid got=%b exp=0", b0.RedirValid); end
        nChk++; if (b0.RedirPc !== '0) begin nErr++; $display("FAIL reset_pc got=%h exp=0", b0.RedirPc); end
        nChk++; if (b0.RedirSrc !== 2'b00) begin nErr++; $display("FAIL reset_src got=%b exp=00", b0.RedirSrc); end
        nChk++; if (b0.FlushFe !== 1'b0) begin nErr++; $display("FAIL reset_flush got=%b exp=0", b0.FlushFe); end
        nChk++; if (b0.StallFe !== 1'b0) begin nErr++; $display("FAIL reset_stall got=%b exp=0", b0.StallFe); end
        nChk++; if (b0.Busy !== 1'b0) begin nErr++; $display("FAIL reset_busy got=%b exp=0", b0.Busy); end
`ifdef FE_REDIR_PERF_EN
        nChk++; if (b0.PerfRobCnt !== '0 || b0.PerfPreCnt !== '0 || b0.PerfTrapCnt !== '0) begin
            nErr++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", b0.PerfRobCnt, b0.PerfPreCnt, b0.PerfTrapCnt);
        end
`endif
    endtask

    task automatic test_rob_basic();
        b0.RobRedir = 1; b0.RobPc = 32'h1c000100;
        tick();
        clear_in();
        nChk++; if ({b0.FlushFe, b0.RedirValid, b0.StallFe} !== 3'b111) begin nErr++; $display("FAIL rob_c1_flags got=%b exp=111", {b0.FlushFe, b0.RedirValid, b0.StallFe}); end
        nChk++; if (b0.RedirPc !== 32'h1c000100) begin nErr++; $display("FAIL rob_c1_pc got=%h exp=1c000100", b0.RedirPc); end
        nChk++; if (b0.RedirSrc !== 2'b01) begin nErr++; $display("FAIL rob_c1_src got=%b exp=01", b0.RedirSrc); end
        for (int c = 2; c <= 3; c++) begin
            tick();
            nChk++; if ({b0.StallFe, b0.FlushFe, b0.RedirValid, b0.Busy} !== 4'b1001) begin
                nErr++; $display("FAIL rob_c%0d_recover got=%b exp=1001", c, {b0.StallFe, b0.FlushFe, b0.RedirValid, b0.Busy});
            end
            nChk++; if (b0.RedirPc !== 32'h1c000100) begin nErr++; $display("FAIL rob_c%0d_pchold got=%h exp=1c000100", c, b0.RedirPc); end
        end
        tick();
        nChk++; if ({b0.Busy, b0.StallFe, b0.RedirSrc} !== 4'b0000) begin nErr++; $display("FAIL rob_c4_idle got=%b exp=0000", {b0.Busy, b0.StallFe, b0.RedirSrc}); end
    endtask

    task automatic test_priority();
        b0.RobRedir = 1; b0.RobPc = 32'h100; b0.PreRedir = 1; b0.PrePc = 32'h200;
        tick();
        clear_in();
        nChk++; if (b0.RedirPc !== 32'h100 || b0.RedirSrc !== 2'b01) begin nErr++; $display("FAIL prio_pc got=%h/%b exp=100/01", b0.RedirPc, b0.RedirSrc); end
        tick(); tick(); tick();
        nChk++; if (b0.Busy !== 1'b0) begin nErr++; $display("FAIL prio_dropped got=%b exp=0", b0.Busy); end
        tick();
        nChk++; if (b0.Busy !== 1'b0 || b0.FlushFe !== 1'b0) begin nErr++; $display("FAIL prio_noqueue got=%b%b exp=00", b0.Busy, b0.FlushFe); end
    endtask

    task automatic test_preempt();
        b0.PreRedir = 1; b0.PrePc = 32'h200;
        tick();
        clear_in();
        nChk++; if (b0.FlushFe !== 1'b1 || b0.RedirPc !== 32'h200 || b0.RedirSrc !== 2'b10) begin
            nErr++; $display("FAIL pre_c1 got=%b/%h/%b exp=1/200/10", b0.FlushFe, b0.RedirPc, b0.RedirSrc);
        end
        tick();
        b0.RobRedir = 1; b0.RobPc = 32'h300;
        tick();
        clear_in();
        nChk++; if (b0.FlushFe !== 1'b1 || b0.RedirPc !== 32'h300 || b0.RedirSrc !== 2'b01) begin
            nErr++; $display("FAIL preempt_c3 got=%b/%h/%b exp=1/300/01", b0.FlushFe, b0.RedirPc, b0.RedirSrc);
        end
        tick(); tick();
        nChk++; if (b0.StallFe !== 1'b1 || b0.FlushFe !== 1'b0) begin nErr++; $display("FAIL preempt_c5 got=%b%b exp=10", b0.StallFe, b0.FlushFe); end
        tick();
        nChk++; if (b0.Busy !== 1'b0) begin nErr++; $display("FAIL preempt_c6 got=%b exp=0", b0.Busy); end
    endtask

    task automatic test_trap();
        b0.BpTrap = 1;
        tick();
        clear_in();
        nChk++; if (b0.StallFe !== 1'b1 || b0.Busy !== 1'b1 || b0.FlushFe !== 1'b0 || b0.RedirSrc !== 2'b00) begin
            nErr++; $display("FAIL trap_c1 got=%b%b%b/%b exp=110/00", b0.StallFe, b0.Busy, b0.FlushFe, b0.RedirSrc);
        end
        for (int c = 1; c < 11; c++) begin
            b0.PreRedir = (c == 5); b0.PrePc = 32'h900;
            b0.BpTrap   = (c == 7);
            b0.RobRedir = (c == 10); b0.RobPc = 32'h400;
            tick();
            if (c + 1 < 11) begin
                nChk++; if (b0.StallFe !== 1'b1 || b0.FlushFe !== 1'b0) begin
                    nErr++; $display("FAIL trap_hold_c%0d got=%b%b exp=10", c + 1, b0.StallFe, b0.FlushFe);
                end
            end
        end
        clear_in();
        nChk++; if (b0.FlushFe !== 1'b1 || b0.RedirPc !== 32'h400 || b0.RedirSrc !== 2'b01) begin
            nErr++; $display("FAIL trap_exit got=%b/%h/%b exp=1/400/01", b0.FlushFe, b0.RedirPc, b0.RedirSrc);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        b0.RobRedir = 1; b0.RobPc = 32'h500;
        tick();
        clear_in();
        tick();
        Rest = 1; b0.RobRedir = 1; b0.RobPc = 32'h501;
        tick();
        Rest = 0; clear_in();
        nChk++; if ({b0.Busy, b0.StallFe, b0.FlushFe, b0.RedirValid, b0.RedirSrc} !== 6'b0 || b0.RedirPc !== '0) begin
            nErr++; $display("FAIL midreset got=%b%b%b%b/%b/%h exp=0000/00/0", b0.Busy, b0.StallFe, b0.FlushFe, b0.RedirValid, b0.RedirSrc, b0.RedirPc);
        end
        b0.PreRedir = 1; b0.PrePc = 32'h600;
        tick();
        clear_in();
        nChk++; if (b0.FlushFe !== 1'b1 || b0.RedirPc !== 32'h600 || b0.RedirSrc !== 2'b10) begin
            nErr++; $display("FAIL post_reset_pre got=%b/%h/%b exp=1/600/10", b0.FlushFe, b0.RedirPc, b0.RedirSrc);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_recover0();
        b1.RobRedir = 1; b1.RobPc = 32'h700;
        tick();
        clear_in();
        nChk++; if (b1.FlushFe !== 1'b1 || b1.RedirPc !== 32'h700) begin nErr++; $display("FAIL rc0_flush got=%b/%h exp=1/700", b1.FlushFe, b1.RedirPc); end
        tick();
        nChk++; if (b1.Busy !== 1'b0 || b1.StallFe !== 1'b0 || b1.FlushFe !== 1'b0) begin
            nErr++; $display("FAIL rc0_idle got=%b%b%b exp=000", b1.Busy, b1.StallFe, b1.FlushFe);
        end
    endtask

`ifdef FE_REDIR_PERF_EN
    task automatic test_perf();
        Rest = 1; tick(); Rest = 0;
        b0.RobRedir = 1; b0.RobPc = 32'h10; tick(); clear_in(); tick(); tick(); tick();
        b0.RobRedir = 1; b0.RobPc = 32'h20; tick(); clear_in(); tick(); tick(); tick();
        b0.BpTrap = 1; tick(); clear_in(); tick();
        b0.RobRedir = 1; b0.RobPc = 32'h30; tick(); clear_in(); tick(); tick(); tick();
        b0.PreRedir = 1; b0.PrePc = 32'h40; tick(); clear_in(); tick(); tick(); tick();
        nChk++; if (b0.PerfRobCnt !== 16'd3 || b0.PerfPreCnt !== 16'd1 || b0.PerfTrapCnt !== 16'd1) begin
            nErr++; $display("FAIL perf_counts got=%0d/%0d/%0d exp=3/1/1", b0.PerfRobCnt, b0.PerfPreCnt, b0.PerfTrapCnt);
        end
    endtask
`endif

    task automatic test_random();
        bit              r, p, t, rs, idle, live;
        logic [PC_W-1:0] expPc;
        logic [1:0]      expSrc;
        bit              expFlush, expStall;
        clear_in();
        Rest = 1; tick(); Rest = 0;
        mAge = -1; mTrap = 0; mPc = '0; mSrc = 2'b00;
        mRobCnt = 0; mPreCnt = 0; mTrapCnt = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            r  = ($urandom_range(0, 11) == 0);
            p  = ($urandom_range(0, 5) == 0);
            t  = ($urandom_range(0, 9) == 0);
            rs = ($urandom_range(0, 59) == 0);
            b0.RobRedir = r; b0.RobPc = $urandom;
            b0.PreRedir = p; b0.PrePc = $urandom;
            b0.BpTrap = t;
            Rest = rs;
            tick();
            idle = !mTrap && (mAge < 0 || mAge > RC);
            if (rs) begin
                mAge = -1; mTrap = 0; mPc = '0; mSrc = 2'b00;
                mRobCnt = 0; mPreCnt = 0; mTrapCnt = 0;
            end else if (r) begin
                mAge = 0; mTrap = 0; mPc = b0.RobPc; mSrc = 2'b01; mRobCnt++;
            end else if (idle && p) begin
                mAge = 0; mPc = b0.PrePc; mSrc = 2'b10; mPreCnt++;
            end else if (idle && t) begin
                mTrap = 1; mTrapCnt++;
            end else if (mAge >= 0 && mAge <= RC) begin
                mAge++;
            end
            live     = (mAge >= 0 && mAge <= RC);
            expFlush = (mAge == 0);
            expStall = mTrap || live;
            expPc    = live ? mPc : '0;
            expSrc   = live ? mSrc : 2'b00;
            nChk++; if (b0.FlushFe !== expFlush) begin nErr++; $display("FAIL rand_flush cyc=%0d got=%b exp=%b", cyc, b0.FlushFe, expFlush); end
            nChk++; if (b0.RedirValid !== expFlush) begin nErr++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, b0.RedirValid, expFlush); end
            nChk++; if (b0.StallFe !== expStall) begin nErr++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, b0.StallFe, expStall); end
            nChk++; if (b0.Busy !== expStall) begin nErr++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, b0.Busy, expStall); end
            nChk++; if (b0.RedirPc !== expPc) begin nErr++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", cyc, b0.RedirPc, expPc); end
            nChk++; if (b0.RedirSrc !== expSrc) begin nErr++; $display("FAIL rand_src cyc=%0d got=%b exp=%b", cyc, b0.RedirSrc, expSrc); end
        end
        clear_in();
        Rest = 0;
`ifdef FE_REDIR_PERF_EN
        nChk++; if (b0.PerfRobCnt !== 16'(mRobCnt) || b0.PerfPreCnt !== 16'(mPreCnt) || b0.PerfTrapCnt !== 16'(mTrapCnt)) begin
            nErr++; $display("FAIL rand_perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", b0.PerfRobCnt, b0.PerfPreCnt, b0.PerfTrapCnt, mRobCnt, mPreCnt, mTrapCnt);
        end
`endif
    endtask

    initial begin
        nErr = 0;
        nChk = 0;
        Rest = 1;
        clear_in();
        test_reset();
        test_rob_basic();
        test_priority();
        test_preempt();
        test_trap();
        test_reset_mid();
        test_recover0();
`ifdef FE_REDIR_PERF_EN
        test_perf();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule
